fir_frame_sequencer: RTL and testbench

Frame-level controller for the pipelined `fir_filter`. Buffers one frame of up to MAX_LEN signed samples from an upstream valid/ready source, clears the filter's delay line, then streams the frame into the filter on consecutive cycles, followed by TAPS-1 zero samples to flush it. It qualifies the filter output with valid/last flags, so downstream logic receives exactly the full linear convolution (frame_len+TAPS-1 samples) and no stale or bubble data. The filter has no enable or valid and must always see a gap-free sample stream.

---
 rtl/fir_frame_sequencer_if.sv | 39 +++
 rtl/fir_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_fir_frame_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_frame_sequencer_if.sv
// Bus bundle between fir_frame_sequencer and its surroundings: the upstream
// sample source, the attached fir_filter and the downstream sink.
//   start/frame_len          frame request (sampled in IDLE)
//   in_valid/in_ready/in_data upstream valid/ready sample stream
//   filt_rst/filt_x/filt_y   filter control, input sample, filter output
//   out_valid/out_data/out_last qualified convolution output stream
//   busy/done/err            status
// master: host/environment side, slave: sequencer side.
interface fir_frame_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 7
);
  logic                     start;
  logic [LEN_W-1:0]         frame_len;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     filt_rst;
  logic signed [DATA_W-1:0] filt_x;
  logic signed [DATA_W-1:0] filt_y;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start, frame_len, in_valid, in_data, filt_y,
    input  in_ready, filt_rst, filt_x, out_valid, out_data, out_last,
           busy, done, err
  );

  modport slave (
    input  start, frame_len, in_valid, in_data, filt_y,
    output in_ready, filt_rst, filt_x, out_valid, out_data, out_last,
           busy, done, err
  );
endinterface

// File: rtl/fir_frame_sequencer.sv
// Frame controller for a pipelined fir_filter. Buffers one frame from the
// upstream stream, pulses the filter reset for one cycle, streams the frame
// gap-free into the filter followed by TAPS-1 zeros, and qualifies the
// filter output so exactly frame_len+TAPS-1 beats leave on out_valid.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  fir_frame_sequencer_if.slave (request, upstream stream, filter
//        connection, output stream, status)
module fir_frame_sequencer #(
  parameter int DATA_W  = 16,
  parameter int TAPS    = 5,
  parameter int LATENCY = 2,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_frame_sequencer_if.slave  bus
);

  localparam int AW   = $clog2(MAX_LEN);
  localparam int FL_W = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(TAPS - 2);

  typedef enum logic [2:0] {IDLE, FILL, CLEAR, STREAM, FLUSH, DRAIN} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] mem [MAX_LEN];
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         wr_ptr;
  logic [LEN_W-1:0]         rd_ptr;
  logic [FL_W-1:0]          fl_cnt;
  logic [LATENCY:0]         vpipe;
  logic [LATENCY:0]         lpipe;
  logic                     filt_rst_q;
  logic signed [DATA_W-1:0] filt_x_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     err_q;
  logic                     len_ok;

  assign len_ok = (bus.frame_len != '0) && (bus.frame_len <= LEN_W'(MAX_LEN));

  // Frame buffer: written only while filling, never reset.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.in_valid) begin
      mem[wr_ptr[AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fl_cnt     <= '0;
      vpipe      <= '0;
      lpipe      <= '0;
      filt_rst_q <= 1'b1;
      filt_x_q   <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q      <= 1'b0;
      filt_rst_q <= 1'b0;
      out_data_q <= bus.filt_y;
      // state is STREAM/FLUSH exactly while filt_x holds a convolution input,
      // so the valid bit travels alongside that sample through the filter.
      vpipe <= {vpipe[LATENCY-1:0], (state == STREAM) || (state == FLUSH)};
      lpipe <= {lpipe[LATENCY-1:0], (state == FLUSH) && (fl_cnt == FL_LAST)};
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (len_ok) begin
              len_q  <= bus.frame_len;
              wr_ptr <= '0;
              rd_ptr <= '0;
              state  <= FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (bus.in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == len_q - 1'b1) begin
              filt_rst_q <= 1'b1;
              state      <= CLEAR;
            end
          end
        end
        CLEAR: begin
          // Preload the first sample so STREAM starts with data on filt_x.
          filt_x_q <= mem[0];
          rd_ptr   <= LEN_W'(1);
          state    <= STREAM;
        end
        STREAM: begin
          if (rd_ptr == len_q) begin
            filt_x_q <= '0;
            fl_cnt   <= '0;
            state    <= FLUSH;
          end else begin
            filt_x_q <= mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
          end
        end
        FLUSH: begin
          if (fl_cnt == FL_LAST) begin
            state <= DRAIN;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (lpipe[LATENCY]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == FILL);
  assign bus.busy      = (state != IDLE);
  assign bus.filt_rst  = filt_rst_q;
  assign bus.filt_x    = filt_x_q;
  assign bus.out_valid = vpipe[LATENCY];
  assign bus.out_last  = lpipe[LATENCY];
  assign bus.done      = lpipe[LATENCY];
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fir_frame_sequencer.sv
module tb_fir_frame_sequencer;
  localparam int DATA_W  = 16;
  localparam int TAPS    = 5;
  localparam int LATENCY = 2;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_frame_sequencer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  fir_frame_sequencer #(
    .DATA_W(DATA_W), .TAPS(TAPS), .LATENCY(LATENCY),
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Stand-in fir_filter: direct-form FIR, output LATENCY cycles after the
  // sample is taken, cleared by filt_rst.
  int coef [TAPS] = '{3, -1, 4, -2, 1};
  int dl [TAPS] = '{default: 0};
  logic signed [DATA_W-1:0] fp [LATENCY] = '{default: '0};

  always @(posedge clk) begin : filt_model
    int acc;
    if (bus.filt_rst) begin
      for (int k = 0; k < TAPS; k++) dl[k] = 0;
      for (int k = 0; k < LATENCY; k++) fp[k] <= '0;
    end else begin
      for (int k = TAPS - 1; k > 0; k--) dl[k] = dl[k-1];
      dl[0] = int'(bus.filt_x);
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += coef[k] * dl[k];
      fp[0] <= acc[DATA_W-1:0];
      for (int k = 1; k < LATENCY; k++) fp[k] <= fp[k-1];
    end
  end
  assign bus.filt_y = fp[LATENCY-1];

  // Monitor: filt_x stream after the filter clear, output beats, pulses.
  int xq[$], oq[$], lq[$], cq[$];
  int nclr = 0, ndone = 0, nerr = 0, cyc = 0;
  int clr_gen = 0, clr_seen = 0;
  bit capx = 1'b0;

  always @(negedge clk) begin
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      xq.delete(); oq.delete(); lq.delete(); cq.delete();
      nclr = 0; ndone = 0; nerr = 0; capx = 1'b0;
    end
    cyc++;
    if (rst && bus.busy && bus.filt_rst) begin
      nclr++;
      capx = 1'b1;
    end else if (capx && bus.busy) begin
      xq.push_back(int'(bus.filt_x));
    end else begin
      capx = 1'b0;
    end
    if (bus.out_valid) begin
      oq.push_back(int'(bus.out_data));
      lq.push_back(int'(bus.out_last));
      cq.push_back(cyc);
    end
    if (bus.done) ndone++;
    if (bus.err) nerr++;
  end

  int total = 0;
  int bad = 0;
  int sq[$];

  task automatic check(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Full linear convolution of the frame, wrapped to DATA_W bits.
  function automatic int ref_y(int n);
    int acc = 0;
    logic signed [DATA_W-1:0] t;
    for (int k = 0; k < TAPS; k++)
      if (n - k >= 0 && n - k < sq.size()) acc += coef[k] * sq[n-k];
    t = acc[DATA_W-1:0];
    return int'(t);
  endfunction

  task automatic feed(int gapmax, bit junk);
    foreach (sq[i]) begin
      int g = int'($urandom_range(gapmax, 0));
      bus.in_valid = 1'b0;
      repeat (g) @(negedge clk);
      check($sformatf("in_ready s%0d", i), int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(sq[i]);
      @(negedge clk);
    end
    bus.in_valid = junk;
    bus.in_data  = 16'sh7fff;
  endtask

  task automatic wait_done(string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check({tag, " done_seen"}, int'(seen), 1);
    @(negedge clk);
    check({tag, " busy_after"}, int'(bus.busy), 0);
  endtask

  task automatic check_frame(string tag);
    int n = sq.size() + TAPS - 1;
    check({tag, " filt_rst_cycles"}, nclr, 1);
    check({tag, " x_len_ok"}, int'(xq.size() >= n), 1);
    for (int i = 0; i < n && i < xq.size(); i++)
      check($sformatf("%s x[%0d]", tag, i), xq[i], (i < sq.size()) ? sq[i] : 0);
    check({tag, " beats"}, oq.size(), n);
    for (int i = 0; i < oq.size(); i++) begin
      check($sformatf("%s y[%0d]", tag, i), oq[i], ref_y(i));
      check($sformatf("%s last[%0d]", tag, i), lq[i], int'(i == n - 1));
      check($sformatf("%s beat_gap[%0d]", tag, i), cq[i] - cq[0], i);
    end
    check({tag, " done_count"}, ndone, 1);
    check({tag, " err_count"}, nerr, 0);
  endtask

  task automatic run(string tag, int gapmax, bit junk);
    clr_gen++;
    bus.frame_len = LEN_W'(sq.size());
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " busy_start"}, int'(bus.busy), 1);
    check({tag, " in_ready_start"}, int'(bus.in_ready), 1);
    feed(gapmax, junk);
    wait_done(tag);
    bus.in_valid = 1'b0;
    check_frame(tag);
  endtask

  task automatic bad_len(int len);
    string tag = $sformatf("badlen%0d", len);
    clr_gen++;
    bus.frame_len = LEN_W'(len);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " err"}, int'(bus.err), 1);
    check({tag, " busy"}, int'(bus.busy), 0);
    check({tag, " in_ready"}, int'(bus.in_ready), 0);
    @(negedge clk);
    check({tag, " err_drop"}, int'(bus.err), 0);
    check({tag, " busy2"}, int'(bus.busy), 0);
    check({tag, " in_ready2"}, int'(bus.in_ready), 0);
    check({tag, " err_count"}, nerr, 1);
  endtask

  initial begin
    bit seen;
    rst = 1'b0;
    bus.start = 1'b1;
    bus.frame_len = LEN_W'(5);
    bus.in_valid = 1'b0;
    bus.in_data = '0;

    // Reset held with start asserted.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d filt_rst", c), int'(bus.filt_rst), 1);
      check($sformatf("rst%0d in_ready", c), int'(bus.in_ready), 0);
      check($sformatf("rst%0d filt_x", c), int'(bus.filt_x), 0);
      check($sformatf("rst%0d out_valid", c), int'(bus.out_valid), 0);
      check($sformatf("rst%0d out_data", c), int'(bus.out_data), 0);
      check($sformatf("rst%0d out_last", c), int'(bus.out_last), 0);
      check($sformatf("rst%0d busy", c), int'(bus.busy), 0);
      check($sformatf("rst%0d done", c), int'(bus.done), 0);
      check($sformatf("rst%0d err", c), int'(bus.err), 0);
    end
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_rst busy", int'(bus.busy), 0);
    check("post_rst err", int'(bus.err), 0);
    check("post_rst in_ready", int'(bus.in_ready), 0);
    check("post_rst filt_rst", int'(bus.filt_rst), 0);

    // Basic 5-sample frame.
    sq = '{1, 2, 3, 4, 5};
    run("basic", 0, 1'b0);

    // Bursty input, in_valid left high with junk after the frame.
    sq = '{10, -20, 30, -40};
    run("bursty", 3, 1'b1);

    // Rejected lengths.
    bad_len(0);
    bad_len(MAX_LEN + 1);

    // Full-depth frame with random data.
    sq.delete();
    for (int i = 0; i < MAX_LEN; i++) sq.push_back(int'($urandom_range(4000)) - 2000);
    run("maxlen", 0, 1'b0);

    // Random length and gaps.
    sq.delete();
    for (int i = 0; i < int'($urandom_range(40, 1)); i++)
      sq.push_back(int'($urandom_range(60000)) - 30000);
    run("rand", 2, 1'b0);

    // Abort a 10-sample frame during STREAM.
    sq.delete();
    for (int i = 0; i < 10; i++) sq.push_back(int'($urandom_range(4000)) - 2000);
    clr_gen++;
    bus.frame_len = LEN_W'(10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    feed(0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (xq.size() >= 4) seen = 1'b1;
    end
    check("abort reached_stream", int'(seen), 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort out_valid", int'(bus.out_valid), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort filt_rst", int'(bus.filt_rst), 1);
    clr_gen++;
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("abort late_beats", oq.size(), 0);
    check("abort late_done", ndone, 0);
    sq = '{7, 7, 7};
    run("after_abort", 0, 1'b0);

    // Back-to-back with start held high.
    sq.delete();
    for (int i = 0; i < 3; i++) sq.push_back(int'($urandom_range(4000)) - 2000);
    clr_gen++;
    bus.frame_len = LEN_W'(3);
    bus.start = 1'b1;
    @(negedge clk);
    check("b2b1 busy_start", int'(bus.busy), 1);
    feed(1, 1'b0);
    wait_done("b2b1");
    check_frame("b2b1");
    clr_gen++;
    sq.delete();
    for (int i = 0; i < 3; i++) sq.push_back(int'($urandom_range(4000)) - 2000);
    @(negedge clk);
    check("b2b2 accepted_in_ready", int'(bus.in_ready), 1);
    check("b2b2 accepted_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    feed(1, 1'b0);
    wait_done("b2b2");
    check_frame("b2b2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
